stopwatch_ctrl_fsm: RTL and testbench



---
 rtl/stopwatch_ctrl_fsm_if.sv | 22 ++
 rtl/stopwatch_ctrl_fsm.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_ctrl_fsm.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_fsm_if.sv
// Switch inputs and run-control outputs of the stopwatch sequencer.
// master: switch/board side driving raw switches; slave: the sequencer.
interface stopwatch_ctrl_fsm_if;
    logic       start;
    logic       stop;
    logic       reset;
    logic       lap;
    logic       enable_count;
    logic       reset_count;
    logic       freeze;
    logic [2:0] state;

    modport master (
        output start, stop, reset, lap,
        input  enable_count, reset_count, freeze, state
    );

    modport slave (
        input  start, stop, reset, lap,
        output enable_count, reset_count, freeze, state
    );
endinterface

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch run-control sequencer: synchronises, debounces and edge-detects
// the raw start/stop/reset/lap switches and sequences IDLE/RUN/PAUSE/LAP/CLEAR.
// Optional lap/split support is built only when STOPWATCH_LAP_EN is defined;
// otherwise the lap switch is ignored, LAP is unreachable and freeze is 0.
module stopwatch_ctrl_fsm #(
    parameter int unsigned DB_CYCLES  = 1000000,
    parameter int unsigned CLR_CYCLES = 100000001
) (
    input logic                 clk,
    input logic                 rst_n,
    stopwatch_ctrl_fsm_if.slave bus
);

    localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
`ifdef STOPWATCH_LAP_EN
    localparam int unsigned NSW = 4;
`else
    localparam int unsigned NSW = 3;
`endif
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        LAP   = 3'd3,
        CLEAR = 3'd4
    } state_t;

    // Switch bit order: 0=start, 1=stop, 2=reset, 3=lap (lap only when enabled)
    logic [NSW-1:0]           raw;
    logic [NSW-1:0]           sync_a;
    logic [NSW-1:0]           sync_b;
    logic [NSW-1:0]           db;
    logic [NSW-1:0]           db_d;
    logic [NSW-1:0]           rise;
    logic [NSW-1:0][DB_W-1:0] db_cnt;

    logic             p_start, p_stop, p_reset, p_lap;
    logic             a_start, a_stop, a_lap;
    logic [2:0]       state_q, next_state;
    logic [CLR_W-1:0] clr_cnt, clr_next;
    logic             en_q, rc_q;

`ifdef STOPWATCH_LAP_EN
    assign raw = {bus.lap, bus.reset, bus.stop, bus.start};
`else
    assign raw = {bus.reset, bus.stop, bus.start};
`endif

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: level follows the synced input after DB_CYCLES stable cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db     <= '0;
            db_d   <= '0;
            db_cnt <= '0;
        end else begin
            db_d <= db;
            for (int i = 0; i < int'(NSW); i++) begin
                if (sync_b[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise    = db & ~db_d;
    assign p_start = rise[0];
    assign p_stop  = rise[1];
    assign p_reset = rise[2];
`ifdef STOPWATCH_LAP_EN
    assign p_lap   = rise[3];
`else
    assign p_lap   = 1'b0;
`endif

    // Only the highest-priority pulse acts (reset > stop > start > lap)
    assign a_stop  = p_stop & ~p_reset;
    assign a_start = p_start & ~p_stop & ~p_reset;
    assign a_lap   = p_lap & ~p_start & ~p_stop & ~p_reset;

    // Next-state and clear-hold counter
    always_comb begin
        next_state = state_q;
        clr_next   = clr_cnt;
        case (state_q)
            IDLE: begin
                if (a_start) next_state = RUN;
            end
            RUN: begin
                if (a_stop)     next_state = PAUSE;
                else if (a_lap) next_state = LAP;
            end
            LAP: begin
                if (a_stop)     next_state = PAUSE;
                else if (a_lap) next_state = RUN;
            end
            PAUSE: begin
                if (a_start) next_state = RUN;
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    next_state = IDLE;
                    clr_next   = '0;
                end else begin
                    clr_next = clr_cnt + CLR_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                clr_next   = '0;
            end
        endcase
        // Reset from any legal state, restarting the hold if already clearing
        if (p_reset && (state_q <= CLEAR)) begin
            next_state = CLEAR;
            clr_next   = '0;
        end
    end

    // State register with outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            clr_cnt <= '0;
            en_q    <= 1'b0;
            rc_q    <= 1'b0;
        end else begin
            state_q <= next_state;
            clr_cnt <= clr_next;
            en_q    <= (next_state == RUN) || (next_state == LAP);
            rc_q    <= (next_state == CLEAR);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic fr_q;

    // Display freeze held only while in LAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_q <= 1'b0;
        end else begin
            fr_q <= (next_state == LAP);
        end
    end

    assign bus.freeze = fr_q;
`else
    assign bus.freeze = 1'b0;
`endif

    assign bus.state        = state_q;
    assign bus.enable_count = en_q;
    assign bus.reset_count  = rc_q;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Directed bench for stopwatch_ctrl_fsm with DB_CYCLES=4, CLR_CYCLES=8.
// Expected outputs are queued when a step is driven and checked when due.
module tb_stopwatch_ctrl_fsm;

    localparam int unsigned DB  = 4;
    localparam int unsigned CLR = 8;

    localparam logic [3:0] M_NONE  = 4'b0000;
    localparam logic [3:0] M_START = 4'b0001;
    localparam logic [3:0] M_STOP  = 4'b0010;
    localparam logic [3:0] M_RESET = 4'b0100;
    localparam logic [3:0] M_LAP   = 4'b1000;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_LAP   = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;

    logic clk = 1'b0;
    logic rst_n;

    stopwatch_ctrl_fsm_if bus_if ();

    stopwatch_ctrl_fsm #(
        .DB_CYCLES  (DB),
        .CLR_CYCLES (CLR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [5:0] sb_val[$];
    string      sb_tag[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sw(input logic [3:0] m);
        bus_if.start = m[0];
        bus_if.stop  = m[1];
        bus_if.reset = m[2];
        bus_if.lap   = m[3];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st,
                              input logic en, input logic rc, input logic fr);
        sb_val.push_back({st, en, rc, fr});
        sb_tag.push_back(tag);
    endtask

    // Compare {state, enable_count, reset_count, freeze} with the oldest expectation
    task automatic check_out();
        logic [5:0] obs;
        logic [5:0] exp;
        string      tag;
        obs = {bus_if.state, bus_if.enable_count, bus_if.reset_count, bus_if.freeze};
        checks++;
        assert (sb_val.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow: observed=%0h expected=queued entry", obs);
        end
        if (sb_val.size() != 0) begin
            exp = sb_val.pop_front();
            tag = sb_tag.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed={st,en,rc,fr}=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    // Debounced press: action lands 2+DB+1 edges after the raw rise, then release
    task automatic press(input logic [3:0] m, input string tag, input logic [2:0] st,
                         input logic en, input logic rc, input logic fr);
        set_sw(m);
        expect_out(tag, st, en, rc, fr);
        tick(DB + 3);
        check_out();
        set_sw(M_NONE);
        tick(DB + 2);
    endtask

    // Reset press (optionally re-pressed as early as debounce allows); measures clear hold
    task automatic clear_run(input bit twice, input int exp_len, input string tag);
        int cnt;
        bit done;
        cnt  = 0;
        done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            if (cyc <= 4 || (twice && cyc >= 9)) set_sw(M_RESET);
            else                                 set_sw(M_NONE);
            tick(1);
            if (bus_if.reset_count) begin
                cnt++;
                if (cnt == 1) chk({tag, "_state_clear"}, 32'(bus_if.state), 32'(S_CLEAR));
            end else if (cnt > 0) begin
                done = 1'b1;
            end
        end
        chk({tag, "_len"}, 32'(cnt), 32'(exp_len));
        expect_out({tag, "_after"}, S_IDLE, 1'b0, 1'b0, 1'b0);
        check_out();
        set_sw(M_NONE);
        tick(DB + 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        set_sw(M_NONE);
        tick(2);
        expect_out("reset_state", S_IDLE, 1'b0, 1'b0, 1'b0);
        check_out();
        rst_n = 1'b1;
        tick(2);

        // Three-cycle glitch never reaches the debounced level
        set_sw(M_START);
        tick(3);
        set_sw(M_NONE);
        expect_out("glitch", S_IDLE, 1'b0, 1'b0, 1'b0);
        tick(10);
        check_out();

        // Held start: no change after 6 edges, RUN exactly at edge 7
        set_sw(M_START);
        expect_out("lat_edge6", S_IDLE, 1'b0, 1'b0, 1'b0);
        expect_out("lat_edge7", S_RUN, 1'b1, 1'b0, 1'b0);
        tick(DB + 2);
        check_out();
        tick(1);
        check_out();
        expect_out("start_held", S_RUN, 1'b1, 1'b0, 1'b0);
        tick(10);
        check_out();
        set_sw(M_NONE);
        tick(DB + 2);

        press(M_STOP, "run_stop", S_PAUSE, 1'b0, 1'b0, 1'b0);
        press(M_START, "pause_start", S_RUN, 1'b1, 1'b0, 1'b0);
        press(M_START | M_STOP, "start_stop_same", S_PAUSE, 1'b0, 1'b0, 1'b0);
        press(M_LAP, "pause_lap_ignored", S_PAUSE, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while running
        press(M_START, "run_again", S_RUN, 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst_immediate", S_IDLE, 1'b0, 1'b0, 1'b0);
        check_out();
        tick(1);
        rst_n = 1'b1;
        tick(1);
        expect_out("after_rst_release", S_IDLE, 1'b0, 1'b0, 1'b0);
        check_out();

        // Clear hold: single press holds CLR cycles; earliest re-press (DB=4)
        // lands on the last clear cycle, so the hold restarts after CLR cycles
        press(M_START, "run_for_clear", S_RUN, 1'b1, 1'b0, 1'b0);
        clear_run(1'b0, CLR, "clear1");
        press(M_START, "run_for_clear2", S_RUN, 1'b1, 1'b0, 1'b0);
        clear_run(1'b1, CLR + CLR, "clear2");

        press(M_START, "run_for_lap", S_RUN, 1'b1, 1'b0, 1'b0);
`ifdef STOPWATCH_LAP_EN
        press(M_LAP, "lap_enter", S_LAP, 1'b1, 1'b0, 1'b1);
        press(M_LAP, "lap_split", S_RUN, 1'b1, 1'b0, 1'b0);
        press(M_LAP, "lap_reenter", S_LAP, 1'b1, 1'b0, 1'b1);
        press(M_STOP, "lap_stop", S_PAUSE, 1'b0, 1'b0, 1'b0);
`else
        press(M_LAP, "lap_off1", S_RUN, 1'b1, 1'b0, 1'b0);
        press(M_LAP, "lap_off2", S_RUN, 1'b1, 1'b0, 1'b0);
        press(M_STOP, "lap_off_stop", S_PAUSE, 1'b0, 1'b0, 1'b0);
`endif

        // Illegal encoding recovers to IDLE with outputs cleared
        press(M_START, "run_for_illegal", S_RUN, 1'b1, 1'b0, 1'b0);
        force dut.state_q = 3'd6;
        tick(1);
        release dut.state_q;
        tick(1);
        expect_out("illegal_recover", S_IDLE, 1'b0, 1'b0, 1'b0);
        check_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
